// File: rtl/float_types_pkg.sv
// Floating-point types shared by the summator and its result buffer.
package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_status_e;

    typedef struct packed {
        fp_status_e     status;
        float_point_num num;
    } fp_result_t;

    localparam int FP_RESULT_W = $bits(fp_result_t);

endpackage

// File: rtl/fp_result_fifo.sv
// First-word-fall-through FIFO of summator results.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module fp_result_fifo
    import float_types_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  fp_result_t             wr_data,
    input  logic                   pop,
    output fp_result_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fp_result_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so the outputs read clean.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_sum_result_buffer.sv
// Result buffer behind the pipelined FP summator: re-times the issue strobe,
// captures answers when they become valid and grants issue credit so the
// FIFO can never be overrun by a well-behaved issuer.
module fp_sum_result_buffer
    import float_types_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_vld_i,
    output logic                   issue_rdy_o,
    input  logic [31:0]            sum_answer_i,
    input  logic [1:0]             sum_status_i,
    output logic                   res_vld_o,
    input  logic                   res_rdy_i,
    output logic [31:0]            res_o,
    output logic [1:0]             res_status_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LATENCY-1:0] vld_pipe;
    logic [31:0]        in_flight;
    logic               capture;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    fp_result_t         cap_data;
    fp_result_t         head;

    assign capture  = vld_pipe[LATENCY-1];
    assign cap_data = fp_result_t'({sum_status_i, sum_answer_i});
    assign pop      = res_vld_o && res_rdy_i;

    // Shift the issue strobe so it lines up with the summator answer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue_vld_i;
            for (int k = 1; k < LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Count operands still travelling through the summator.
    always_comb begin
        in_flight = '0;
        for (int k = 0; k < LATENCY; k++) in_flight = in_flight + 32'(vld_pipe[k]);
    end

    // Credit is derived from registers only; a pop frees credit one cycle later.
    assign issue_rdy_o = (32'(count) + in_flight) < 32'(DEPTH);

    // Sticky flag for a capture that found the FIFO full with no pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow_o <= 1'b0;
        end else if (capture && full && !pop) begin
            overflow_o <= 1'b1;
        end
    end

    fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (capture),
        .wr_data (cap_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign res_vld_o    = !empty;
    assign res_o        = head.num;
    assign res_status_o = head.status;
    assign count_o      = count;

endmodule

// File: tb/tb_fp_sum_result_buffer.sv
module tb_fp_sum_result_buffer;
    import float_types_pkg::*;

    localparam int DEPTH   = 8;
    localparam int LATENCY = 3;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_vld_i;
    logic        issue_rdy_o;
    logic [31:0] sum_answer_i;
    logic [1:0]  sum_status_i;
    logic        res_vld_o;
    logic        res_rdy_i;
    logic [31:0] res_o;
    logic [1:0]  res_status_o;
    logic [3:0]  count_o;
    logic        overflow_o;

    // Stand-in summator: the operand presented with an issue appears on the
    // answer bus LATENCY edges later.
    logic [31:0] op_ans, p0, p1, p2;
    logic [1:0]  op_st, s0, s1, s2;

    int n_vec = 0;
    int n_err = 0;

    fp_sum_result_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_vld_i  (issue_vld_i),
        .issue_rdy_o  (issue_rdy_o),
        .sum_answer_i (sum_answer_i),
        .sum_status_i (sum_status_i),
        .res_vld_o    (res_vld_o),
        .res_rdy_i    (res_rdy_i),
        .res_o        (res_o),
        .res_status_o (res_status_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        p0 <= op_ans; p1 <= p0; p2 <= p1;
        s0 <= op_st;  s1 <= s0; s2 <= s1;
    end
    assign sum_answer_i = p2;
    assign sum_status_i = s2;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_vld_i = 1'($urandom_range(0, 1));
            res_rdy_i   = 1'($urandom_range(0, 1));
            op_ans      = $urandom();
            op_st       = 2'($urandom_range(0, 3));
            tick();
        end
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", res_vld_o); end
        n_vec++; if (res_o !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h want 00000000", res_o); end
        n_vec++; if (res_status_o !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b want 00", res_status_o); end
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        n_vec++; if (issue_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", issue_rdy_o); end
        issue_vld_i = 1'b0; res_rdy_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        rst_i = 1'b1;
        repeat (5) tick();
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_release_count: got %0d want 0", count_o); end
    endtask

    task automatic test_single();
        res_rdy_i = 1'b0;
        op_ans = 32'h4044CCCD; op_st = FP_NORMAL; issue_vld_i = 1'b1;
        tick();
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b11;
        tick(); tick();
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL single_early_vld: got %b want 0", res_vld_o); end
        tick();
        n_vec++; if (res_vld_o !== 1'b1) begin n_err++; $display("FAIL single_vld: got %b want 1", res_vld_o); end
        n_vec++; if (res_o !== 32'h4044CCCD) begin n_err++; $display("FAIL single_res: got %h want 4044cccd", res_o); end
        n_vec++; if (res_status_o !== 2'b00) begin n_err++; $display("FAIL single_status: got %b want 00", res_status_o); end
        n_vec++; if (count_o !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count_o); end
        res_rdy_i = 1'b1;
        tick();
        res_rdy_i = 1'b0;
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL single_drain_count: got %0d want 0", count_o); end
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL single_drain_vld: got %b want 0", res_vld_o); end
    endtask

    task automatic test_credit();
        int n;
        n = 0;
        res_rdy_i = 1'b0;
        while (issue_rdy_o && n < 12) begin
            op_ans = 32'h41000000 + 32'(n); op_st = 2'(n); issue_vld_i = 1'b1;
            tick();
            n++;
        end
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        n_vec++; if (n !== 8) begin n_err++; $display("FAIL credit_issues: got %0d want 8", n); end
        repeat (4) tick();
        n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL credit_count: got %0d want 8", count_o); end
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL credit_ovf: got %b want 0", overflow_o); end
        n_vec++; if (issue_rdy_o !== 1'b0) begin n_err++; $display("FAIL credit_rdy_full: got %b want 0", issue_rdy_o); end
        res_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (res_vld_o !== 1'b1) begin n_err++; $display("FAIL credit_drain_vld[%0d]: got %b want 1", i, res_vld_o); end
            n_vec++; if (res_o !== 32'h41000000 + 32'(i)) begin n_err++; $display("FAIL credit_drain_res[%0d]: got %h want %h", i, res_o, 32'h41000000 + 32'(i)); end
            n_vec++; if (res_status_o !== 2'(i)) begin n_err++; $display("FAIL credit_drain_status[%0d]: got %b want %b", i, res_status_o, 2'(i)); end
            tick();
        end
        res_rdy_i = 1'b0;
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL credit_end_count: got %0d want 0", count_o); end
        n_vec++; if (issue_rdy_o !== 1'b1) begin n_err++; $display("FAIL credit_end_rdy: got %b want 1", issue_rdy_o); end
    endtask

    task automatic test_overflow();
        res_rdy_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            op_ans = 32'h42000000 + 32'(i); op_st = 2'(i); issue_vld_i = 1'b1;
            tick();
        end
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        repeat (4) tick();
        n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count_o); end
        res_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (res_o !== 32'h42000000 + 32'(i)) begin n_err++; $display("FAIL ovf_drain_res[%0d]: got %h want %h", i, res_o, 32'h42000000 + 32'(i)); end
            tick();
        end
        res_rdy_i = 1'b0;
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL ovf_ninth_absent: got vld %b res %h want vld 0", res_vld_o, res_o); end
        n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
        rst_i = 1'b0;
        tick();
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_reset_clear: got %b want 0", overflow_o); end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_res;
        logic [1:0]  exp_st;
        res_rdy_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op_ans = 32'h43000000 + 32'(i); op_st = 2'(i); issue_vld_i = 1'b1;
            tick();
        end
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        repeat (4) tick();
        n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fpp_fill_count: got %0d want 8", count_o); end
        op_ans = 32'h43800000; op_st = FP_INF; issue_vld_i = 1'b1;
        tick();
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        tick(); tick();
        res_rdy_i = 1'b1;
        tick();
        res_rdy_i = 1'b0;
        n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fpp_count: got %0d want 8", count_o); end
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %b want 0", overflow_o); end
        res_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_res = (i < 7) ? 32'h43000000 + 32'(i + 1) : 32'h43800000;
            exp_st  = (i < 7) ? 2'(i + 1) : 2'b10;
            n_vec++; if (res_o !== exp_res) begin n_err++; $display("FAIL fpp_drain_res[%0d]: got %h want %h", i, res_o, exp_res); end
            n_vec++; if (res_status_o !== exp_st) begin n_err++; $display("FAIL fpp_drain_status[%0d]: got %b want %b", i, res_status_o, exp_st); end
            tick();
        end
        res_rdy_i = 1'b0;
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL fpp_end_count: got %0d want 0", count_o); end
    endtask

    task automatic test_reset_midflight();
        res_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op_ans = 32'h44000000 + 32'(i); op_st = 2'b01; issue_vld_i = 1'b1;
            tick();
        end
        issue_vld_i = 1'b0; op_ans = JUNK; op_st = 2'b00;
        tick();
        n_vec++; if (count_o !== 4'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d want 3", count_o); end
        #1 rst_i = 1'b0;
        #1;
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL mid_async_count: got %0d want 0", count_o); end
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL mid_async_vld: got %b want 0", res_vld_o); end
        n_vec++; if (res_o !== 32'h0) begin n_err++; $display("FAIL mid_async_res: got %h want 00000000", res_o); end
        #1 rst_i = 1'b1;
        repeat (4) tick();
        n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL mid_after_count: got %0d want 0", count_o); end
        n_vec++; if (res_vld_o !== 1'b0) begin n_err++; $display("FAIL mid_after_vld: got %b want 0", res_vld_o); end
        n_vec++; if (issue_rdy_o !== 1'b1) begin n_err++; $display("FAIL mid_after_rdy: got %b want 1", issue_rdy_o); end
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL mid_after_ovf: got %b want 0", overflow_o); end
    endtask

    initial begin
        rst_i = 1'b0;
        issue_vld_i = 1'b0;
        res_rdy_i = 1'b0;
        op_ans = JUNK;
        op_st = 2'b00;
        test_reset();
        test_single();
        test_credit();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_sum_result_buffer.md
Name: fp_sum_result_buffer

Overview:
Downstream companion of pipilined_fp_summator. The summator has no output valid and no backpressure, so this block does three things:
- re-times the operand-issue strobe through a LATENCY-deep valid pipe;
- captures answer_o/num_status_o into a small FIFO exactly when they are valid;
- presents results on a valid/ready interface and returns a credit-based issue_rdy_o so the issuer never overruns the buffer.

Parameters:
LATENCY, 3, clock edges from issue_vld_i being sampled to the summator answer being capturable (>=1)
DEPTH, 8, FIFO entries; power of two, >=2

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
issue_vld_i  input  1  same strobe driven to the summator vld_i
issue_rdy_o  output  1  issue permitted this cycle (credit available)
sum_answer_i  input  32  summator answer_o (float_point_num)
sum_status_i  input  2  summator num_status_o (fp_status_e)
res_vld_o  output  1  head entry valid
res_rdy_i  input  1  consumer accepts head
res_o  output  32  head result (float_point_num)
res_status_o  output  2  head status
count_o  output  $clog2(DEPTH)+1  FIFO occupancy
overflow_o  output  1  sticky: a capture was dropped

Behaviour:
- Reset (rst_i=0, async): clears valid pipe, pointers, count and overflow.
  - Reset values: res_vld_o=0, res_o=0, res_status_o=0, count_o=0, overflow_o=0, issue_rdy_o=1 once the register state is cleared.
  - Reset mid-operation discards all in-flight and stored results. Answers presented after release are not captured unless re-issued.
- Valid pipe: vld_pipe[0] <= issue_vld_i; vld_pipe[k] <= vld_pipe[k-1].
  - capture = vld_pipe[LATENCY-1].
  - Issue sampled at edge N means sum_answer_i/sum_status_i are sampled at edge N+LATENCY.
  - The pipe shifts every cycle; issue_vld_i is recorded regardless of issue_rdy_o.
- Credit:
  - in_flight = popcount(vld_pipe).
  - issue_rdy_o = (count + in_flight) < DEPTH.
  - Purely registered; no combinational path from issue_vld_i or res_rdy_i.
  - A same-cycle pop is not credited until the next cycle (conservative).
- Push: on capture, write {sum_status_i, sum_answer_i} at wr_ptr.
- Pop: when res_vld_o && res_rdy_i, advance rd_ptr.
- Outputs:
  - First-word-fall-through: res_vld_o = (count != 0); res_o/res_status_o = mem[rd_ptr].
  - When count == 0, res_o and res_status_o are forced to 0.
- Boundary conditions:
  - Simultaneous push and pop: count unchanged; allowed even when full, with no overflow.
  - Push when full and no pop: entry dropped, overflow_o set to 1 and held until reset; count stays DEPTH.
  - Pop when empty: impossible, since res_vld_o=0; res_rdy_i is ignored.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count saturates logically at DEPTH.
- Order: strictly FIFO; results leave in issue order.
- Latency: the first result is visible on res_o the cycle after capture edge N+LATENCY.

Decomposition:
- float_types_pkg (extend the existing package):
  - float_point_num struct (already present).
  - fp_status_e enum, 2 bits: FP_NORMAL=2'b00, FP_ZERO=2'b01, FP_INF=2'b10, FP_NAN=2'b11.
  - fp_result_t packed struct {fp_status_e status; float_point_num num;}.
- One sub-module, fp_result_fifo:
  - Synchronous FWFT FIFO of fp_result_t, parameter DEPTH.
  - Ports: push, pop, full, empty, count.
  - Async active-low reset.
- fp_sum_result_buffer keeps the valid pipe, credit logic and overflow flag.

Test Plan:
- Reset: hold rst_i=0 with random inputs -> res_vld_o=0, res_o=0, count_o=0, overflow_o=0, issue_rdy_o=1.
- Single result: issue_vld_i pulse at edge N; drive sum_answer_i=0x4044CCCD (3.075 = 0.875 + 2.2) with FP_NORMAL before edge N+3 -> after N+3, res_vld_o=1, res_o=0x4044CCCD, res_status_o=2'b00. With res_rdy_i=1, count_o returns to 0 one edge later.
- Credit backpressure (DEPTH=8): res_rdy_i=0, issue on every cycle while issue_rdy_o=1 -> issue_rdy_o falls after the 8th issue. count_o reaches 8, overflow_o=0, values drain in order once res_rdy_i=1.
- Overflow: ignore issue_rdy_o and issue a 9th operand with FIFO full and res_rdy_i=0 -> overflow_o=1 sticky, count_o=8, 9th value absent, the first 8 drain in order.
- Full simultaneous push/pop: count_o=8, capture with res_rdy_i=1 in the same cycle -> count_o stays 8, overflow_o=0, new entry lands at the tail.
- Reset mid-flight: 2 entries in the pipe and 3 in the FIFO, pulse rst_i low -> count_o=0 and res_vld_o=0 immediately. Answers arriving in the following 3 cycles are not captured.
